// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Shared definitions for the CPU memory access unit: access size
//             codes, FSM state type and lane/alignment helper functions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    // Access size codes as presented on the size input.
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mau_state_t;

    // Byte lanes touched by an access of the given size at the given
    // byte offset within the word. Illegal size touches nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // A request is rejected without touching memory when it is not
    // naturally aligned or uses the reserved size code.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Combinational byte-lane steering. Replicates store data across
//             the lanes of the addressed word, produces the lane write mask,
//             and extracts/extends the addressed lane(s) of a loaded word.
//  Ports    : i_size, i_addr_lo, i_sign_ext  - captured access attributes
//             i_store_data / o_write_data    - store data in / replicated out
//             o_byte_mask                    - lanes written by the access
//             i_load_word / o_load_data      - raw memory word / extended result
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sign_ext,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [31:0] o_write_data,
    output logic [3:0]  o_byte_mask,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;

    always_comb begin
        o_byte_mask  = lane_mask(i_size, i_addr_lo);
        o_write_data = i_store_data;
        o_load_data  = i_load_word;
        w_load_byte  = i_load_word[7:0];
        w_load_half  = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

        case (i_addr_lo)
            2'd0:    w_load_byte = i_load_word[7:0];
            2'd1:    w_load_byte = i_load_word[15:8];
            2'd2:    w_load_byte = i_load_word[23:16];
            default: w_load_byte = i_load_word[31:24];
        endcase

        // Word accesses (and the never-issued illegal size) pass straight through.
        case (i_size)
            SZ_BYTE: begin
                o_write_data = {4{i_store_data[7:0]}};
                o_load_data  = {{24{i_sign_ext & w_load_byte[7]}}, w_load_byte};
            end
            SZ_HALF: begin
                o_write_data = {2{i_store_data[15:0]}};
                o_load_data  = {{16{i_sign_ext & w_load_half[15]}}, w_load_half};
            end
            default: begin
                o_write_data = i_store_data;
                o_load_data  = i_load_word;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Turns a level-held load/store request from the CPU control FSM
//             into a timed single-port memory transaction with WAIT_STATES
//             wait cycles, answering with a four-phase acknowledge, extended
//             load data and a misalignment error flag.
//  Ports    : CLOCK_50, resetIn (async, active-low)
//             enable, isLoad, size, signExt, ADDout, RD   - request side
//             loadData, acknowledge, error                - response side
//             address, dataWrite, byteEnable, writeEnable - memory side
//             readData                                    - memory read data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int WAIT_STATES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              CLOCK_50,
    input  logic              resetIn,
    input  logic              enable,
    input  logic              isLoad,
    input  logic [1:0]        size,
    input  logic              signExt,
    input  logic [DATA_W-1:0] ADDout,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] loadData,
    output logic              acknowledge,
    output logic              error,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataWrite,
    output logic [3:0]        byteEnable,
    output logic              writeEnable,
    input  logic [DATA_W-1:0] readData
);

    // Elaboration-time parameter guards.
    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("mem_access_unit: DATA_W must be 32");
        end
        if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("mem_access_unit: WAIT_STATES must be in 1..15");
        end
        if (ADDR_W < 1 || ADDR_W + 2 > DATA_W) begin : g_bad_addr_w
            $error("mem_access_unit: ADDR_W out of range");
        end
        // Byte-address bits above the memory's reach are deliberately ignored.
        if (ADDR_W + 2 < DATA_W) begin : g_addr_hi_unused
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^ADDout[DATA_W-1:ADDR_W+2];
        end
    endgenerate

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES - 1);

    mau_state_t        r_state;
    mau_state_t        w_next_state;
    logic [3:0]        r_wait_cnt;
    logic              r_is_load;
    logic [1:0]        r_size;
    logic              r_sign_ext;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_load_data;
    logic              r_error;

    logic              w_req_misaligned;
    logic [31:0]       w_write_data;
    logic [3:0]        w_lane_mask;
    logic [31:0]       w_load_ext;

    assign w_req_misaligned = is_misaligned(size, ADDout[1:0]);

    // Lane steering always works from the captured request so that the
    // memory side stays stable while the requester's inputs wander.
    mem_lane_align u_lane_align (
        .i_size       (r_size),
        .i_addr_lo    (r_addr[1:0]),
        .i_sign_ext   (r_sign_ext),
        .i_store_data (r_wdata),
        .i_load_word  (readData),
        .o_write_data (w_write_data),
        .o_byte_mask  (w_lane_mask),
        .o_load_data  (w_load_ext)
    );

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_is_load   <= 1'b0;
            r_size      <= SZ_BYTE;
            r_sign_ext  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_load_data <= 32'd0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_is_load  <= isLoad;
                        r_size     <= size;
                        r_sign_ext <= signExt;
                        r_addr     <= ADDout[ADDR_W+1:0];
                        r_wdata    <= RD;
                        r_error    <= w_req_misaligned;
                    end
                end
                ST_ISSUE: r_wait_cnt <= c_WAIT_LOAD;
                ST_WAIT: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else if (r_is_load) begin
                        // readData is valid on the last WAIT cycle.
                        r_load_data <= w_load_ext;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        r_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        acknowledge  = 1'b0;
        error        = 1'b0;
        writeEnable  = 1'b0;
        byteEnable   = 4'b0000;
        address      = r_addr[ADDR_W+1:2];
        dataWrite    = w_write_data;
        loadData     = r_load_data;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = w_req_misaligned ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                byteEnable   = w_lane_mask;
                writeEnable  = ~r_is_load;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                acknowledge = 1'b1;
                error       = r_error;
                // Four-phase: only a low enable releases DONE.
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit. A byte-addressed
//             reference memory and plain-arithmetic rules predict lanes,
//             write data, load results, errors and handshake latency.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_WS = 2;

    logic        CLOCK_50 = 1'b0;
    logic        resetIn, enable, isLoad, signExt;
    logic [1:0]  size;
    logic [31:0] ADDout, RD, readData;
    logic [31:0] loadData, dataWrite;
    logic        acknowledge, error, writeEnable;
    logic [10:0] address;
    logic [3:0]  byteEnable;

    logic        ack_ws1, ack_ws15;
    logic [31:0] unused_ld_ws1, unused_dw_ws1, unused_ld_ws15, unused_dw_ws15;
    logic        unused_err_ws1, unused_we_ws1, unused_err_ws15, unused_we_ws15;
    logic [10:0] unused_addr_ws1, unused_addr_ws15;
    logic [3:0]  unused_be_ws1, unused_be_ws15;

    logic [31:0] mem   [0:2047];
    logic [7:0]  ref_b [0:8191];
    logic [31:0] last_load;
    int          n_checks = 0;
    int          n_errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    mem_access_unit #(.ADDR_W(11), .WAIT_STATES(c_WS), .DATA_W(32)) u_dut (
        .CLOCK_50(CLOCK_50), .resetIn(resetIn), .enable(enable), .isLoad(isLoad),
        .size(size), .signExt(signExt), .ADDout(ADDout), .RD(RD),
        .loadData(loadData), .acknowledge(acknowledge), .error(error),
        .address(address), .dataWrite(dataWrite), .byteEnable(byteEnable),
        .writeEnable(writeEnable), .readData(readData));

    mem_access_unit #(.ADDR_W(11), .WAIT_STATES(1), .DATA_W(32)) u_ws1 (
        .CLOCK_50(CLOCK_50), .resetIn(resetIn), .enable(enable), .isLoad(isLoad),
        .size(size), .signExt(signExt), .ADDout(ADDout), .RD(RD),
        .loadData(unused_ld_ws1), .acknowledge(ack_ws1), .error(unused_err_ws1),
        .address(unused_addr_ws1), .dataWrite(unused_dw_ws1), .byteEnable(unused_be_ws1),
        .writeEnable(unused_we_ws1), .readData(readData));

    mem_access_unit #(.ADDR_W(11), .WAIT_STATES(15), .DATA_W(32)) u_ws15 (
        .CLOCK_50(CLOCK_50), .resetIn(resetIn), .enable(enable), .isLoad(isLoad),
        .size(size), .signExt(signExt), .ADDout(ADDout), .RD(RD),
        .loadData(unused_ld_ws15), .acknowledge(ack_ws15), .error(unused_err_ws15),
        .address(unused_addr_ws15), .dataWrite(unused_dw_ws15), .byteEnable(unused_be_ws15),
        .writeEnable(unused_we_ws15), .readData(readData));

    // Main memory seen by the primary DUT.
    assign readData = mem[address];
    always @(posedge CLOCK_50) begin
        if (writeEnable) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEnable[b]) mem[address][8*b +: 8] <= dataWrite[8*b +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = nbytes(sz);
        if (n == 0) return 1'b1;
        return (int'(a[1:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        be = 4'b0000;
        for (int i = 0; i < nbytes(sz); i++) be[int'(a[1:0]) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_dw(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] dw;
        int n;
        n = nbytes(sz);
        dw = 32'd0;
        for (int i = 0; i < 4; i++) dw[8*i +: 8] = d[8*(i % n) +: 8];
        return dw;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                               input logic [31:0] a);
        logic [31:0] v;
        int n, base;
        n = nbytes(sz);
        base = int'(a[12:0]);
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[base + i];
        if (sx && n < 4 && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        base = int'({a[12:2], 2'b00});
        return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) ref_b[int'(a[12:0]) + i] = d[8*i +: 8];
    endtask

    task automatic preload_word(input int w, input logic [31:0] v);
        mem[w] <= v;
        for (int i = 0; i < 4; i++) ref_b[4*w + i] = v[8*i +: 8];
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Drives one full four-phase transaction, scrambling the non-enable
    // inputs while it is in flight, and records what the DUT showed.
    task automatic run_txn(input logic ld, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] d, input int hold,
                           output int lat, output logic [3:0] be1, output logic [31:0] dw1,
                           output logic [10:0] ad1, output int we_cnt, output logic err,
                           output logic [31:0] ldd, output logic held_ok,
                           output logic ack_after, output logic err_after);
        isLoad = ld; size = sz; signExt = sx; ADDout = a; RD = d; enable = 1'b1;
        lat = -1; we_cnt = 0; be1 = '0; dw1 = '0; ad1 = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (writeEnable) we_cnt++;
            if (k == 1) begin be1 = byteEnable; dw1 = dataWrite; ad1 = address; end
            isLoad = 1'($urandom); size = 2'($urandom); signExt = 1'($urandom);
            ADDout = $urandom; RD = $urandom;
            if (acknowledge) begin lat = k; break; end
        end
        err = error; ldd = loadData; held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!acknowledge) held_ok = 1'b0;
            if (writeEnable) we_cnt++;
        end
        enable = 1'b0;
        tick();
        ack_after = acknowledge; err_after = error;
        if (writeEnable) we_cnt++;
    endtask

    // Shared result holders for the directed tests.
    int lat, we_cnt;
    logic [3:0] be1;
    logic [31:0] dw1, ldd;
    logic [10:0] ad1;
    logic err, held_ok, ack_after, err_after;

    task automatic test_reset();
        resetIn = 1'b0; enable = 1'b0; isLoad = 1'b0; size = 2'd0; signExt = 1'b0;
        ADDout = 32'd0; RD = 32'd0;
        repeat (3) tick();
        n_checks++; if ({acknowledge, error, writeEnable} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {acknowledge, error, writeEnable}); end
        n_checks++; if (byteEnable !== 4'h0) begin n_errors++; $display("FAIL reset_be: got %h expected 0", byteEnable); end
        n_checks++; if (loadData !== 32'h0) begin n_errors++; $display("FAIL reset_loaddata: got %h expected 0", loadData); end
        resetIn = 1'b1;
        tick();
        n_checks++; if (acknowledge !== 1'b0) begin n_errors++; $display("FAIL reset_idle_ack: got %b expected 0", acknowledge); end
        last_load = 32'h0;
    endtask

    task automatic test_store_word();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 2, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        ref_store(2'd2, 32'h10, 32'hDEAD_BEEF);
        n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL sw_latency: got %0d expected 4", lat); end
        n_checks++; if (ad1 !== 11'd4) begin n_errors++; $display("FAIL sw_address: got %0d expected 4", ad1); end
        n_checks++; if (be1 !== 4'hF) begin n_errors++; $display("FAIL sw_be: got %b expected 1111", be1); end
        n_checks++; if (dw1 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sw_data: got %h expected deadbeef", dw1); end
        n_checks++; if (we_cnt !== 1) begin n_errors++; $display("FAIL sw_we_count: got %0d expected 1", we_cnt); end
        n_checks++; if (held_ok !== 1'b1) begin n_errors++; $display("FAIL sw_ack_held: got %b expected 1", held_ok); end
        n_checks++; if (ack_after !== 1'b0) begin n_errors++; $display("FAIL sw_ack_drop: got %b expected 0", ack_after); end
        n_checks++; if (mem[4] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sw_mem: got %h expected deadbeef", mem[4]); end
    endtask

    task automatic test_store_byte();
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 0, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        ref_store(2'd0, 32'h13, 32'hA5);
        n_checks++; if (ad1 !== 11'd4) begin n_errors++; $display("FAIL sb_address: got %0d expected 4", ad1); end
        n_checks++; if (be1 !== 4'b1000) begin n_errors++; $display("FAIL sb_be: got %b expected 1000", be1); end
        n_checks++; if (dw1 !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL sb_data: got %h expected a5a5a5a5", dw1); end
        n_checks++; if (we_cnt !== 1) begin n_errors++; $display("FAIL sb_we_count: got %0d expected 1", we_cnt); end
        n_checks++; if (mem[4] !== ref_word(32'h13)) begin n_errors++; $display("FAIL sb_mem: got %h expected %h", mem[4], ref_word(32'h13)); end
    endtask

    task automatic test_load_half();
        preload_word(8, 32'h8001_1234);
        run_txn(1'b1, 2'd1, 1'b1, 32'h0000_0022, 32'h0, 1, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        n_checks++; if (ldd !== 32'hFFFF_8001) begin n_errors++; $display("FAIL lh_signed: got %h expected ffff8001", ldd); end
        n_checks++; if (we_cnt !== 0) begin n_errors++; $display("FAIL lh_no_write: got %0d expected 0", we_cnt); end
        n_checks++; if (lat !== 2 + c_WS) begin n_errors++; $display("FAIL lh_latency: got %0d expected %0d", lat, 2 + c_WS); end
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0, 0, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        n_checks++; if (ldd !== 32'h0000_8001) begin n_errors++; $display("FAIL lh_unsigned: got %h expected 00008001", ldd); end
        n_checks++; if (loadData !== 32'h0000_8001) begin n_errors++; $display("FAIL lh_hold: got %h expected 00008001", loadData); end
        last_load = 32'h0000_8001;
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0006, $urandom, 1, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL mis_latency: got %0d expected 1", lat); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL mis_error: got %b expected 1", err); end
        n_checks++; if (we_cnt !== 0) begin n_errors++; $display("FAIL mis_no_write: got %0d expected 0", we_cnt); end
        n_checks++; if ({ack_after, err_after} !== 2'b00) begin n_errors++; $display("FAIL mis_release: got %b expected 00", {ack_after, err_after}); end
        run_txn(1'b1, 2'd1, 1'b1, 32'h0000_0105, 32'h0, 0, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        n_checks++; if (ldd !== last_load) begin n_errors++; $display("FAIL mis_load_keeps: got %h expected %h", ldd, last_load); end
        run_txn(1'b0, 2'd3, 1'b0, 32'h0000_0040, $urandom, 0, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        n_checks++; if ({err, we_cnt == 0, lat == 1} !== 3'b111) begin n_errors++; $display("FAIL illegal_size: got err=%b we=%0d lat=%0d expected err=1 we=0 lat=1", err, we_cnt, lat); end
    endtask

    task automatic test_early_drop();
        logic [31:0] d;
        int k_ack, wes;
        d = $urandom; k_ack = -1; wes = 0;
        isLoad = 1'b0; size = 2'd1; signExt = 1'b0; ADDout = 32'h0000_0042; RD = d; enable = 1'b1;
        tick();
        if (writeEnable) wes++;
        enable = 1'b0;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (writeEnable) wes++;
            if (acknowledge) begin k_ack = k; break; end
        end
        tick();
        ref_store(2'd1, 32'h42, d);
        n_checks++; if (k_ack !== 2 + c_WS) begin n_errors++; $display("FAIL early_latency: got %0d expected %0d", k_ack, 2 + c_WS); end
        n_checks++; if (acknowledge !== 1'b0) begin n_errors++; $display("FAIL early_pulse: got %b expected 0", acknowledge); end
        n_checks++; if (wes !== 1) begin n_errors++; $display("FAIL early_we: got %0d expected 1", wes); end
        n_checks++; if (mem[16] !== ref_word(32'h42)) begin n_errors++; $display("FAIL early_mem: got %h expected %h", mem[16], ref_word(32'h42)); end
    endtask

    task automatic test_reset_mid_wait();
        logic bad;
        isLoad = 1'b1; size = 2'd2; signExt = 1'b0; ADDout = 32'h0000_0080; RD = 32'h0; enable = 1'b1;
        tick();
        tick();
        #2 resetIn = 1'b0;
        #1;
        n_checks++; if ({acknowledge, error, writeEnable, byteEnable} !== 7'b0) begin n_errors++; $display("FAIL rst_wait_ctrl: got %b expected 0", {acknowledge, error, writeEnable, byteEnable}); end
        n_checks++; if ({loadData, dataWrite, address} !== 75'b0) begin n_errors++; $display("FAIL rst_wait_data: got ld=%h dw=%h a=%h expected 0", loadData, dataWrite, address); end
        enable = 1'b0;
        tick();
        resetIn = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (acknowledge || writeEnable) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL rst_stays_idle: got %b expected 0", bad); end
        last_load = 32'h0;
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0000_0077, 3, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        ref_store(2'd0, 32'h201, 32'h77);
        n_checks++; if ({we_cnt == 1, held_ok} !== 2'b11) begin n_errors++; $display("FAIL b2b_first: got we=%0d held=%b expected we=1 held=1", we_cnt, held_ok); end
        run_txn(1'b1, 2'd0, 1'b1, 32'h0000_0201, 32'h0, 0, lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
        n_checks++; if (lat !== 2 + c_WS) begin n_errors++; $display("FAIL b2b_accept: got %0d expected %0d", lat, 2 + c_WS); end
        n_checks++; if (ldd !== 32'h0000_0077) begin n_errors++; $display("FAIL b2b_readback: got %h expected 00000077", ldd); end
        last_load = 32'h0000_0077;
    endtask

    task automatic test_latency_param(input logic [1:0] sz, input logic [31:0] a,
                                      input int e1, input int e2, input int e15);
        int l1, l2, l15;
        logic [31:0] d;
        enable = 1'b0;
        repeat (20) tick();
        d = $urandom; l1 = -1; l2 = -1; l15 = -1;
        isLoad = 1'b0; size = sz; signExt = 1'b0; ADDout = a; RD = d; enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ack_ws1 && l1 < 0) l1 = k;
            if (acknowledge && l2 < 0) l2 = k;
            if (ack_ws15 && l15 < 0) l15 = k;
            if (l1 > 0 && l2 > 0 && l15 > 0) break;
        end
        enable = 1'b0;
        tick();
        if (!model_misaligned(sz, a)) ref_store(sz, a, d);
        n_checks++; if (l1 !== e1) begin n_errors++; $display("FAIL lat_ws1: got %0d expected %0d", l1, e1); end
        n_checks++; if (l2 !== e2) begin n_errors++; $display("FAIL lat_ws2: got %0d expected %0d", l2, e2); end
        n_checks++; if (l15 !== e15) begin n_errors++; $display("FAIL lat_ws15: got %0d expected %0d", l15, e15); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic ld, sx;
            logic [1:0] sz;
            logic [31:0] a, d, exp_ld;
            bit mis;
            int n;
            ld = 1'($urandom); sx = 1'($urandom); sz = 2'($urandom_range(0, 3));
            a = $urandom; d = $urandom;
            n = nbytes(sz);
            if (n != 0 && $urandom_range(0, 3) != 0) a[1:0] = 2'(int'(a[1:0]) / n * n);
            mis = model_misaligned(sz, a);
            exp_ld = (ld && !mis) ? model_load(sz, sx, a) : last_load;
            run_txn(ld, sz, sx, a, d, $urandom_range(0, 2), lat, be1, dw1, ad1, we_cnt, err, ldd, held_ok, ack_after, err_after);
            n_checks++; if (lat !== (mis ? 1 : 2 + c_WS)) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, lat, mis ? 1 : 2 + c_WS); end
            n_checks++; if (err !== mis) begin n_errors++; $display("FAIL rnd_error[%0d]: got %b expected %b", t, err, mis); end
            n_checks++; if ({ack_after, err_after, held_ok} !== 3'b001) begin n_errors++; $display("FAIL rnd_handshake[%0d]: got %b expected 001", t, {ack_after, err_after, held_ok}); end
            n_checks++; if (we_cnt !== ((!ld && !mis) ? 1 : 0)) begin n_errors++; $display("FAIL rnd_we_count[%0d]: got %0d expected %0d", t, we_cnt, (!ld && !mis) ? 1 : 0); end
            n_checks++; if (ldd !== exp_ld) begin n_errors++; $display("FAIL rnd_loaddata[%0d]: got %h expected %h", t, ldd, exp_ld); end
            last_load = exp_ld;
            if (!mis) begin
                n_checks++; if (ad1 !== a[12:2]) begin n_errors++; $display("FAIL rnd_address[%0d]: got %h expected %h", t, ad1, a[12:2]); end
            end
            if (!mis && !ld) begin
                ref_store(sz, a, d);
                n_checks++; if (be1 !== model_be(sz, a)) begin n_errors++; $display("FAIL rnd_be[%0d]: got %b expected %b", t, be1, model_be(sz, a)); end
                n_checks++; if (dw1 !== model_dw(sz, d)) begin n_errors++; $display("FAIL rnd_dw[%0d]: got %h expected %h", t, dw1, model_dw(sz, d)); end
                n_checks++; if (mem[a[12:2]] !== ref_word(a)) begin n_errors++; $display("FAIL rnd_mem[%0d]: got %h expected %h", t, mem[a[12:2]], ref_word(a)); end
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 2048; w++) begin
            logic [31:0] v;
            v = $urandom;
            preload_word(w, v);
        end
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_early_drop();
        test_reset_mid_wait();
        test_back_to_back();
        test_latency_param(2'd2, 32'h0000_0300, 3, 4, 17);
        test_latency_param(2'd2, 32'h0000_0302, 1, 1, 1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
